// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the parity-checking receiver.
// Both ends must agree on the oversample ratio and the parity mode.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input bit odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB-first, parity, stop; each bit lasts
// OVERSAMPLE clk_en pulses. tx, busy and done are all registered.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter bit          PARITY_ODD = UART_PARITY_EVEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [TICK_W-1:0]         tick_q, tick_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;

    assign bit_end = clk_en && (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        if (state_q != TX_IDLE && clk_en) begin
            tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
        end
        unique case (state_q)
            TX_IDLE: begin
                if (wr_en) begin
                    shift_d  = din;
                    parity_d = parity_bit(din, PARITY_ODD);
                    tick_d   = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = TX_PARITY;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed one bit ahead of state_q.
    always_comb begin
        tx_d   = tx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                tx_d   = !wr_en;
                busy_d = wr_en;
            end
            TX_START: begin
                if (bit_end) tx_d = shift_q[0];
            end
            TX_DATA: begin
                if (bit_end) tx_d = (bit_idx_q == IDX_LAST) ? parity_q : shift_q[1];
            end
            TX_PARITY: begin
                if (bit_end) tx_d = 1'b1;
            end
            TX_STOP: begin
                if (bit_end) begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Scoreboard bench: even- and odd-parity transmitters share one stimulus stream;
// a line-decoding monitor rebuilds each frame and checks it against the byte queue.
module tb_uart_tx_parity;

    localparam int OS     = 16;
    localparam int FRAME  = 11 * OS;
    localparam int WAIT_MAX = 8000;

    logic       clk = 1'b0;
    logic       reset, clk_en, wr_en;
    logic [7:0] din;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int checks = 0;
    int errors = 0;
    int en_mode;

    logic [7:0] exp_q[$];

    bit         mon_in_frame = 1'b0;
    int         mon_pulses = 0;
    logic [10:0] f0, f1;
    logic       prev_tx0 = 1'b1;
    logic       m_en, m_rst;

    uart_tx_parity #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr_en), .din(din),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_tx_parity #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr_en), .din(din),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Line image of a frame, bit 0 first on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input int odd);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = ((d >> i) & 8'd1) != 0;
        f[9]  = (($countones(d) % 2) == 1) ^ (odd != 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(posedge clk) begin
        int k;
        logic [7:0] d;
        m_en  = clk_en;
        m_rst = reset;
        #1;
        if (m_rst) begin
            mon_in_frame = 1'b0;
        end else if (!mon_in_frame) begin
            if (done0 === 1'b1 || done1 === 1'b1) flag("spurious_done", {done0, done1}, 0);
            if (tx0 === 1'b0) begin
                mon_in_frame = 1'b1;
                mon_pulses   = 0;
                chk("start_busy", {busy0, busy1}, 2'b11);
                chk("start_tx_odd", tx1, 1'b0);
            end else if (tx0 !== 1'b1) begin
                flag("idle_line", tx0, 1);
            end
        end else begin
            if (m_en) mon_pulses++;
            if (m_en && (mon_pulses % OS) == OS / 2) begin
                k = mon_pulses / OS;
                f0[k] = tx0;
                f1[k] = tx1;
            end
            if (tx0 !== prev_tx0 && !(m_en && (mon_pulses % OS) == 0))
                flag("tx_changed_mid_bit", mon_pulses, 0);
            if (mon_pulses == FRAME) begin
                chk("end_done", {done0, done1}, 2'b11);
                chk("end_busy", {busy0, busy1}, 2'b00);
                if (exp_q.size() == 0) begin
                    flag("unexpected_frame", f0, 0);
                end else begin
                    d = exp_q.pop_front();
                    chk("frame_even", f0, model_frame(d, 0));
                    chk("frame_odd", f1, model_frame(d, 1));
                end
                mon_in_frame = 1'b0;
            end else begin
                if (busy0 !== 1'b1 || busy1 !== 1'b1) flag("busy_dropped", {busy0, busy1}, 3);
                if (done0 !== 1'b0 || done1 !== 1'b0) flag("early_done", {done0, done1}, 0);
            end
        end
        prev_tx0 = tx0;
    end

    task automatic step();
        @(posedge clk);
        #2;
        case (en_mode)
            0:       clk_en = ($urandom_range(0, 2) == 0);
            1:       clk_en = 1'b1;
            default: clk_en = 1'b0;
        endcase
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        din   = d;
        wr_en = 1'b1;
        exp_q.push_back(d);
        step();
        din = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done0 !== 1'b1 && n < WAIT_MAX) begin
            step();
            n++;
        end
        if (n >= WAIT_MAX) flag("done_timeout", n, 0);
    endtask

    task automatic wait_pulses(input int target);
        int n = 0;
        while (!(mon_in_frame && mon_pulses >= target) && n < WAIT_MAX) begin
            step();
            n++;
        end
        if (n >= WAIT_MAX) flag("pulse_timeout", mon_pulses, target);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tx"}, {tx0, tx1}, 2'b11);
        chk({tag, "_busy"}, {busy0, busy1}, 2'b00);
        chk({tag, "_done"}, {done0, done1}, 2'b00);
    endtask

    initial begin
        logic held_tx;
        int   held_pulses;
        reset   = 1'b1;
        wr_en   = 1'b0;
        din     = '0;
        clk_en  = 1'b0;
        en_mode = 1;
        repeat (3) step();
        check_reset_state("reset");
        reset = 1'b0;
        repeat (2) step();

        // Directed bytes, back-to-back with the one-cycle minimum gap.
        send(8'h55);
        wait_done();
        send(8'h07);
        wait_done();
        send(8'hA3);
        wait_done();
        send(8'h00);
        wait_done();
        send(8'hFF);
        wait_done();

        // Request while busy is ignored.
        send(8'h96);
        repeat ($urandom_range(5, 160)) step();
        din   = 8'h12;
        wr_en = 1'b1;
        step();
        wait_done();

        // Request on the STOP-to-IDLE edge is ignored.
        send(8'h5A);
        wait_pulses(FRAME - 1);
        din   = 8'h12;
        wr_en = 1'b1;
        step();
        repeat (30) step();
        chk("stop_edge_ignored_busy", busy0, 1'b0);

        // Reset during data bit 4 aborts the frame.
        send(8'hC9);
        wait_pulses(5 * OS + OS / 2);
        reset = 1'b1;
        step();
        check_reset_state("abort");
        reset = 1'b0;
        void'(exp_q.pop_back());
        repeat (20) step();
        chk("abort_idle_tx", tx0, 1'b1);
        send(8'h3C);
        wait_done();

        // clk_en stall holds the current bit.
        en_mode = 0;
        send(8'hB4);
        wait_pulses(3 * OS + 5);
        en_mode = 2;
        step();
        held_tx     = tx0;
        held_pulses = mon_pulses;
        repeat (200) step();
        chk("stall_tx", tx0, held_tx);
        chk("stall_pulses", mon_pulses, held_pulses);
        en_mode = 0;
        wait_done();

        for (int i = 0; i < 30; i++) begin
            en_mode = $urandom_range(0, 1);
            send(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 60)) step();
                din   = 8'($urandom);
                wr_en = 1'b1;
                step();
            end
            wait_done();
            repeat ($urandom_range(0, 3)) step();
        end

        en_mode = 1;
        repeat (FRAME + 20) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
